// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV64IM DIV/DIVU/REM/REMU and the W forms.
// Latency: done in cycle 65 (64-bit) or 33 (W) after launch; divide-by-zero/overflow in cycle 1.
// Backpressure: none; launches are accepted only in IDLE, so the caller stalls while busy is high.
// Ports:
//   clk, reset       - core clock, synchronous active-high reset
//   valid, divide_en - launch request; divide_en = {W, is, type_rem, unsgn}, launch needs divide_en[2]
//   a, b             - dividend (rs1) and divisor (rs2), latched at launch
//   flush            - abort any in-flight operation, done is suppressed
//   busy, done, c    - busy while not IDLE, one-cycle done pulse, result qualified by done
module divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  divide_en,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] c
);

    typedef logic [63:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // W results are always sign-extended from bit 31, even for the unsigned forms.
    function automatic word_t finalize(input logic w, input word_t x);
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    word_t       c_q, c_d;
    logic        w_q, w_d;
    logic        rem_sel_q, rem_sel_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [6:0]  cnt_q, cnt_d;
    word_t       dvs_q, dvs_d;
    word_t       quo_q, quo_d;
    word_t       rem_q, rem_d;

    // Decoded launch fields.
    logic        en_w, en_rem, en_unsgn, is_signed, launch;
    word_t       a_p, b_p, a_mag, b_mag, min_neg;
    logic        a_neg, b_neg, div_zero, ovf;
    word_t       spec_res;

    // One restoring step.
    logic [64:0] rem_sh, diff;
    logic        ge;
    word_t       step_quo, step_rem, quo_fix, rem_fix, run_res;

    always_comb begin
        en_w      = divide_en[3];
        en_rem    = divide_en[1];
        en_unsgn  = divide_en[0];
        is_signed = !en_unsgn;
        launch    = (state_q == IDLE) && valid && divide_en[2] && !flush;

        if (en_w) begin
            a_p = en_unsgn ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            b_p = en_unsgn ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end else begin
            a_p = a;
            b_p = b;
        end

        a_neg = is_signed && a_p[63];
        b_neg = is_signed && b_p[63];
        a_mag = a_neg ? -a_p : a_p;
        b_mag = b_neg ? -b_p : b_p;

        // Most-negative N-bit value in its sign-extended 64-bit form.
        min_neg  = en_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = (b_p == '0);
        ovf      = is_signed && (a_p == min_neg) && (b_p == '1);

        // Divide-by-zero: quotient all ones, remainder = dividend.
        // Overflow: quotient = dividend, remainder = 0.
        if (div_zero) begin
            spec_res = finalize(en_w, en_rem ? a_p : '1);
        end else begin
            spec_res = finalize(en_w, en_rem ? '0 : a_p);
        end

        // Partial remainder is one bit wider than the divisor; bit 64 of the
        // difference is the borrow, clear exactly when rem_sh >= divisor.
        rem_sh   = {rem_q, quo_q[63]};
        diff     = rem_sh - {1'b0, dvs_q};
        ge       = !diff[64];
        step_rem = ge ? diff[63:0] : rem_sh[63:0];
        step_quo = {quo_q[62:0], ge};
        quo_fix  = neg_quo_q ? -step_quo : step_quo;
        rem_fix  = neg_rem_q ? -step_rem : step_rem;
        run_res  = finalize(w_q, rem_sel_q ? rem_fix : quo_fix);
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        w_d       = w_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    w_d       = en_w;
                    rem_sel_d = en_rem;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dvs_d     = b_mag;
                    // W ops run 32 steps, so park the 32-bit magnitude in the
                    // top half where the shifter consumes bits MSB first.
                    quo_d     = en_w ? {a_mag[31:0], 32'b0} : a_mag;
                    rem_d     = '0;
                    cnt_d     = en_w ? 7'd32 : 7'd64;
                    if (div_zero || ovf) begin
                        state_d = DONE;
                        c_d     = spec_res;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = DONE;
                    c_d     = run_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything, including a same-cycle launch or the
        // final step; c keeps its previous value.
        if (flush) begin
            state_d = IDLE;
            c_d     = c_q;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            c_q       <= '0;
            w_q       <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            c_q       <= c_d;
            w_q       <= w_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule

// File: tb/tb_divider.sv
`timescale 1ns/1ps
module tb_divider;

    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b0101;
    localparam logic [3:0] OP_REM   = 4'b0110;
    localparam logic [3:0] OP_REMU  = 4'b0111;
    localparam logic [3:0] OP_DIVW  = 4'b1100;
    localparam logic [3:0] OP_DIVUW = 4'b1101;
    localparam logic [3:0] OP_REMW  = 4'b1110;
    localparam logic [3:0] OP_REMUW = 4'b1111;

    logic        clk = 1'b0;
    logic        reset, valid, flush;
    logic [3:0]  divide_en;
    logic [63:0] a, b;
    logic        busy, done;
    logic [63:0] c;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        logic [63:0] c;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        string       name;
        logic [3:0]  en;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .divide_en (divide_en),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .c         (c)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding
    // expectation in both value and cycle.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cycle %0d c=%h with nothing outstanding", cyc, c);
            end else begin
                mon_e = exp_q.pop_front();
                check64({mon_e.name, "_c"}, c, mon_e.c);
                check64({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: outstanding %0d busy %b want 0 and 0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    // Drive one launch cycle, then scramble the operand buses to prove they
    // were latched.
    task automatic launch(input logic [3:0] en, input logic [63:0] aa, input logic [63:0] bb);
        valid     = 1'b1;
        divide_en = en;
        a         = aa;
        b         = bb;
        tick();
        valid     = 1'b0;
        divide_en = 4'($urandom);
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;

        vecs.push_back('{"div_100_7",      OP_DIV,   64'd100,                 64'd7,                   64'd14,                  65});
        vecs.push_back('{"rem_m100_7",     OP_REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{"divu_by0",       OP_DIVU,  64'd5,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{"remu_by0",       OP_REMU,  64'd5,                   64'd0,                   64'd5,                   1});
        vecs.push_back('{"div_ovf",        OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
        vecs.push_back('{"rem_ovf",        OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1});
        vecs.push_back('{"divw_ovf",       OP_DIVW,  64'h1_8000_0000,         64'hFFFF_FFFF,           64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{"divuw_max_2",    OP_DIVUW, 64'hFFFF_FFFF,           64'd2,                   64'h0000_0000_7FFF_FFFF, 33});
        vecs.push_back('{"remw_m7_2",      OP_REMW,  64'hFFFF_FFF9,           64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{"div_m100_7",     OP_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                   64'hFFFF_FFFF_FFFF_FFF2, 65});
        vecs.push_back('{"div_100_m7",     OP_DIV,   64'd100,                 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65});
        vecs.push_back('{"rem_100_m7",     OP_REM,   64'd100,                 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   65});
        vecs.push_back('{"divu_max_3",     OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3,                   64'h5555_5555_5555_5555, 65});
        vecs.push_back('{"remu_2p63_3",    OP_REMU,  64'h8000_0000_0000_0000, 64'd3,                   64'd2,                   65});
        vecs.push_back('{"divu_max_max",   OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   65});
        vecs.push_back('{"div_minneg_1",   OP_DIV,   64'h8000_0000_0000_0000, 64'd1,                   64'h8000_0000_0000_0000, 65});
        vecs.push_back('{"remuw_7",        OP_REMUW, 64'h8000_0007,           64'h10,                  64'd7,                   33});
        vecs.push_back('{"remuw_by0_hi",   OP_REMUW, 64'hFFFF_FFFF,           64'h1_0000_0000,         64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{"divuw_sext",     OP_DIVUW, 64'h8000_0000,           64'd1,                   64'hFFFF_FFFF_8000_0000, 33});
        vecs.push_back('{"divw_by0",       OP_DIVW,  64'd7,                   64'hABCD_0000_0000,      64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{"remw_ovf",       OP_REMW,  64'h8000_0000,           64'hFFFF_FFFF,           64'd0,                   1});

        reset     = 1'b1;
        valid     = 1'b0;
        flush     = 1'b0;
        divide_en = 4'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_done", 64'(done), 64'd0);
        check64("reset_c", c, 64'd0);

        // Table-driven vectors; results checked by the scoreboard monitor.
        for (int i = 0; i < vecs.size(); i++) begin
            wait_idle();
            exp_q.push_back('{vecs[i].name, vecs[i].c, cyc + vecs[i].lat});
            launch(vecs[i].en, vecs[i].a, vecs[i].b);
        end
        wait_idle();

        // Flush in cycle 10 of a DIV, then a DIVU 9/3 launched in cycle 11.
        l = cyc;
        launch(OP_DIV, 64'd100, 64'd7);
        check64("busy_cycle1", 64'(busy), 64'd1);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check64("busy_after_flush", 64'(busy), 64'd0);
        exp_q.push_back('{"divu_after_flush", 64'd3, l + 76});
        launch(OP_DIVU, 64'd9, 64'd3);
        wait_idle();

        // valid together with flush in IDLE is dropped.
        valid     = 1'b1;
        divide_en = OP_DIV;
        a         = 64'd10;
        b         = 64'd3;
        flush     = 1'b1;
        tick();
        valid = 1'b0;
        flush = 1'b0;
        check64("valid_with_flush_dropped", 64'(busy), 64'd0);

        // valid without the divide enable bit does not launch.
        valid     = 1'b1;
        divide_en = 4'b1011;
        tick();
        valid = 1'b0;
        check64("no_launch_without_en", 64'(busy), 64'd0);
        repeat (3) tick();

        // valid held high through DONE must not start a second operation.
        l = cyc;
        exp_q.push_back('{"hold_valid", 64'hFFFF_FFFF_FFFF_FFFF, l + 1});
        valid     = 1'b1;
        divide_en = OP_DIVU;
        a         = 64'd5;
        b         = 64'd0;
        tick();
        check64("busy_in_done", 64'(busy), 64'd1);
        tick();
        check64("no_relaunch_from_done", 64'(busy), 64'd0);
        valid = 1'b0;
        wait_idle();

        // Reset in cycle 20 of a DIV: outputs clear in cycle 21, no done.
        launch(OP_DIV, 64'd100, 64'd7);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        check64("midreset_busy", 64'(busy), 64'd0);
        check64("midreset_done", 64'(done), 64'd0);
        check64("midreset_c", c, 64'd0);
        reset = 1'b0;
        repeat (70) tick();
        check64("idle_after_midreset", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
